// File: rtl/ldce_bank_arb.sv
// Round-robin arbiter and write sequencer for a shared bank of LDCE latches.
// Each access runs GE setup, a G (or CLR) open window, hold, then an ACK cycle.
module ldce_bank_arb #(
  parameter int NREQ     = 4,
  parameter int NBANK    = 4,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1,
  parameter int BW       = (NBANK > 1) ? $clog2(NBANK) : 1,
  parameter int IW       = $clog2(NREQ)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NREQ-1:0]     REQ,
  input  logic [NREQ-1:0]     REQ_CLR,
  input  logic [NREQ*BW-1:0]  REQ_BANK,
  input  logic [NREQ*DW-1:0]  REQ_DATA,
  output logic [NREQ-1:0]     ACK,
  output logic                ERR,
  output logic [IW-1:0]       GNT_ID,
  output logic                BUSY,
  output logic [DW-1:0]       LAT_D,
  output logic                LAT_G,
  output logic [NBANK-1:0]    LAT_GE,
  output logic [NBANK-1:0]    LAT_CLR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state, nxt;
  logic [IW-1:0]   ptr;
  logic [4:0]      cnt, cnt_n;
  logic            t_clr, f_clr;
  logic [BW-1:0]   t_bank, f_bank;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  logic [IW-1:0]     win;
  logic [DW-1:0]     win_data;

  logic [NBANK-1:0]  oh;
  logic              in_rng;

  logic [NREQ-1:0]   ack_n;
  logic              err_n, busy_n, g_n;
  logic [DW-1:0]     d_n;
  logic [NBANK-1:0]  ge_n, clr_n;

  // Rotate requests so bit 0 is the requester just after ptr; lowest set bit wins.
  always_comb begin
    dbl      = {REQ, REQ};
    rot      = NREQ'(dbl >> (32'(ptr) + 32'd1));
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        win   = IW'((32'(ptr) + 32'd1 + j) % NREQ);
      end
    end
    f_clr  = t_clr;
    f_bank = t_bank;
    if (state == S_IDLE) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (IW'(i) == win) begin
          f_clr    = REQ_CLR[i];
          f_bank   = REQ_BANK[i*BW +: BW];
          win_data = REQ_DATA[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    case (state)
      S_IDLE:  if (found) nxt = S_SETUP;
      S_SETUP: begin
        nxt   = S_OPEN;
        cnt_n = '0;
      end
      S_OPEN: begin
        if (cnt == 5'(OPEN_CYC - 1)) nxt = S_HOLD;
        else cnt_n = cnt + 5'd1;
      end
      S_HOLD:  nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so each output
  // changes on the same edge as the state it belongs to.
  always_comb begin
    oh = '0;
    for (int unsigned b = 0; b < NBANK; b++) oh[b] = (32'(f_bank) == b);
    in_rng = (32'(f_bank) < NBANK);

    d_n = (state == S_IDLE && found) ? win_data : LAT_D;
    g_n = (nxt == S_OPEN) && !f_clr;
    ge_n = '0;
    if (nxt == S_SETUP || ((nxt == S_OPEN || nxt == S_HOLD) && !f_clr))
      ge_n = oh;
    clr_n = '0;
    if (nxt == S_OPEN && f_clr) clr_n = oh;
    ack_n = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      ack_n[i] = (nxt == S_DONE) && (IW'(i) == GNT_ID);
    err_n  = (nxt == S_DONE) && !in_rng;
    busy_n = (nxt != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      ptr     <= IW'(NREQ - 1);
      cnt     <= '0;
      t_clr   <= 1'b0;
      t_bank  <= '0;
      GNT_ID  <= '0;
      ACK     <= '0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      LAT_D   <= '0;
      LAT_G   <= 1'b0;
      LAT_GE  <= '0;
      LAT_CLR <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      if (state == S_IDLE && found) begin
        ptr    <= win;
        GNT_ID <= win;
        t_clr  <= f_clr;
        t_bank <= f_bank;
      end
      ACK     <= ack_n;
      ERR     <= err_n;
      BUSY    <= busy_n;
      LAT_D   <= d_n;
      LAT_G   <= g_n;
      LAT_GE  <= ge_n;
      LAT_CLR <= clr_n;
    end
  end

endmodule

// File: tb/tb_ldce_bank_arb.sv
// Directed bench for ldce_bank_arb: one OPEN_CYC=1 instance with a 3-bit bank
// field (out-of-range banks reachable) plus a latch model, and one OPEN_CYC=3 instance.
module tb_ldce_bank_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req0, clr0, ack0, ge0, lclr0;
  logic [11:0] bank0;
  logic [31:0] data0;
  logic        err0, busy0, g0;
  logic [1:0]  gnt0;
  logic [7:0]  d0;

  logic [3:0]  req1, clr1, ack1, ge1, lclr1;
  logic [7:0]  bank1;
  logic [31:0] data1;
  logic        err1, busy1, g1;
  logic [1:0]  gnt1;
  logic [7:0]  d1;

  int errors = 0;
  int checks = 0;

  ldce_bank_arb #(.NREQ(4), .NBANK(4), .DW(8), .OPEN_CYC(1), .BW(3)) u0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req0), .REQ_CLR(clr0), .REQ_BANK(bank0),
    .REQ_DATA(data0), .ACK(ack0), .ERR(err0), .GNT_ID(gnt0), .BUSY(busy0),
    .LAT_D(d0), .LAT_G(g0), .LAT_GE(ge0), .LAT_CLR(lclr0)
  );

  ldce_bank_arb #(.NREQ(4), .NBANK(4), .DW(8), .OPEN_CYC(3)) u1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req1), .REQ_CLR(clr1), .REQ_BANK(bank1),
    .REQ_DATA(data1), .ACK(ack1), .ERR(err1), .GNT_ID(gnt1), .BUSY(busy1),
    .LAT_D(d1), .LAT_G(g1), .LAT_GE(ge1), .LAT_CLR(lclr1)
  );

  // LDCE bank model for u0: clear dominates, transparent while G and GE are high.
  logic [7:0] mem [4];
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lclr0[b]) mem[b] <= 8'h00;
      else if (g0 && ge0[b]) mem[b] <= d0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input int i, input logic c, input int bnk, input logic [7:0] d);
    clr0[i] = c;
    bank0[i*3 +: 3] = 3'(bnk);
    data0[i*8 +: 8] = d;
  endtask

  task automatic set1(input int i, input logic c, input int bnk, input logic [7:0] d);
    clr1[i] = c;
    bank1[i*2 +: 2] = 2'(bnk);
    data1[i*8 +: 8] = d;
  endtask

  initial begin
    for (int b = 0; b < 4; b++) mem[b] = 8'h00;
    rst_n = 1'b0;
    req0 = '0; clr0 = '0; bank0 = '0; data0 = '0;
    req1 = '0; clr1 = '0; bank1 = '0; data1 = '0;
    tick(); tick();
    chk("rst_busy", busy0, 0);
    chk("rst_gnt", gnt0, 0);
    chk("rst_ge", ge0, 0);
    chk("rst_d", d0, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy0, 0);

    // Requester 1 writes 0xA5 to bank 2
    set0(1, 1'b0, 2, 8'hA5);
    req0 = 4'b0010;
    tick();
    chk("t1_c1_busy", busy0, 1);
    chk("t1_c1_ge", ge0, 4'b0100);
    chk("t1_c1_g", g0, 0);
    chk("t1_c1_d", d0, 8'hA5);
    chk("t1_c1_gnt", gnt0, 1);
    tick();
    chk("t1_c2_g", g0, 1);
    chk("t1_c2_ge", ge0, 4'b0100);
    tick();
    chk("t1_c3_g", g0, 0);
    chk("t1_c3_ge", ge0, 4'b0100);
    chk("t1_c3_d", d0, 8'hA5);
    tick();
    chk("t1_c4_ack", ack0, 4'b0010);
    chk("t1_c4_ge", ge0, 0);
    chk("t1_c4_err", err0, 0);
    req0 = '0;
    tick();
    chk("t1_c5_busy", busy0, 0);
    chk("t1_c5_ack", ack0, 0);
    chk("t1_mem2", mem[2], 8'hA5);

    // All four request at once after reset: grants 0,1,2,3, five cycles apart
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set0(i, 1'b0, i, (i == 3) ? 8'hFF : 8'(8'h10 + i));
    req0 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_gnt", gnt0, i);
      tick(); tick(); tick();
      chk("t2_ack", ack0, 1 << i);
      req0[i] = 1'b0;
      tick();
      chk("t2_idle", busy0, 0);
    end
    chk("t2_mem0", mem[0], 8'h10);
    chk("t2_mem2", mem[2], 8'h12);
    chk("t2_mem3", mem[3], 8'hFF);

    // Requester 3 clears bank 3
    set0(3, 1'b1, 3, 8'h00);
    req0 = 4'b1000;
    tick();
    chk("t3_c1_ge", ge0, 4'b1000);
    tick();
    chk("t3_c2_clr", lclr0, 4'b1000);
    chk("t3_c2_g", g0, 0);
    chk("t3_c2_ge", ge0, 0);
    tick();
    chk("t3_c3_clr", lclr0, 0);
    tick();
    chk("t3_c4_ack", ack0, 4'b1000);
    req0 = '0;
    clr0 = '0;
    tick();
    chk("t3_mem3", mem[3], 8'h00);

    // Out-of-range bank 5: sequence runs, no enables, ERR with ACK
    set0(2, 1'b0, 5, 8'h3C);
    req0 = 4'b0100;
    tick();
    chk("t4_c1_ge", ge0, 0);
    chk("t4_c1_err", err0, 0);
    chk("t4_c1_busy", busy0, 1);
    tick();
    chk("t4_c2_ge", ge0, 0);
    chk("t4_c2_clr", lclr0, 0);
    tick(); tick();
    chk("t4_c4_ack", ack0, 4'b0100);
    chk("t4_c4_err", err0, 1);
    req0 = '0;
    tick();
    chk("t4_c5_err", err0, 0);
    chk("t4_mem2", mem[2], 8'h12);
    chk("t4_mem1", mem[1], 8'h11);

    // Reset during OPEN aborts without ACK; then requester 0 wins first
    set0(1, 1'b0, 0, 8'h77);
    req0 = 4'b0010;
    tick(); tick();
    chk("t5_open_g", g0, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_g", g0, 0);
    chk("t5_rst_ge", ge0, 0);
    chk("t5_rst_d", d0, 0);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_gnt", gnt0, 0);
    tick();
    chk("t5_rst_ack", ack0, 0);
    set0(0, 1'b0, 1, 8'h55);
    set0(2, 1'b0, 2, 8'h66);
    req0 = 4'b0101;
    rst_n = 1'b1;
    tick();
    chk("t5_gnt_first", gnt0, 0);
    chk("t5_ge_first", ge0, 4'b0010);
    tick(); tick(); tick();
    chk("t5_ack_first", ack0, 4'b0001);
    req0[0] = 1'b0;
    tick(); tick();
    chk("t5_gnt_second", gnt0, 2);
    tick(); tick(); tick();
    chk("t5_ack_second", ack0, 4'b0100);
    req0 = '0;
    tick();
    chk("t5_mem1", mem[1], 8'h55);

    // OPEN_CYC=3 instance: G high for cycles 2-4, ACK in 6, next SETUP in 8
    set1(0, 1'b0, 1, 8'h9A);
    set1(1, 1'b0, 2, 8'h3B);
    req1 = 4'b0011;
    tick();
    chk("t6_c1_g", g1, 0);
    chk("t6_c1_ge", ge1, 4'b0010);
    chk("t6_c1_gnt", gnt1, 0);
    tick();
    chk("t6_c2_g", g1, 1);
    tick();
    chk("t6_c3_g", g1, 1);
    tick();
    chk("t6_c4_g", g1, 1);
    tick();
    chk("t6_c5_g", g1, 0);
    chk("t6_c5_ge", ge1, 4'b0010);
    chk("t6_c5_ack", ack1, 0);
    tick();
    chk("t6_c6_ack", ack1, 4'b0001);
    req1[0] = 1'b0;
    tick();
    chk("t6_c7_busy", busy1, 0);
    tick();
    chk("t6_c8_busy", busy1, 1);
    chk("t6_c8_gnt", gnt1, 1);
    chk("t6_c8_ge", ge1, 4'b0100);
    chk("t6_c8_d", d1, 8'h3B);
    tick(); tick(); tick(); tick(); tick();
    chk("t6_c13_ack", ack1, 4'b0010);
    req1 = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
